// File: rtl/spi_daisy_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_daisy_slave_if
// Brief    : SPI pins plus receive valid/ready handshake for spi_daisy_slave.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_daisy_slave_if #(
    parameter int DATA_W = 8
);
    logic              sclk;
    logic              cs;
    logic              mosi;
    logic              miso;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              overrun;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  sclk, cs, mosi, tx_data, rx_ready,
        output miso, rx_data, rx_valid, overrun, frame_err, busy
    );

    modport master (
        output sclk, cs, mosi, tx_data, rx_ready,
        input  miso, rx_data, rx_valid, overrun, frame_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_daisy_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_daisy_slave
// Brief    : SPI mode-0 daisy-chain slave, oversampled in the clk domain.
//            Optional SPI_DAISY_SYNC_EN adds a second synchronizer flop.
// Revision : 1.0 - initial release
// ============================================================================
module spi_daisy_slave #(
    parameter int DATA_W = 8
) (
    input wire                 clk,
    input wire                 rst,
    spi_daisy_slave_if.slave   bus
);
    localparam int                CNT_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_W - 1);

    localparam logic [1:0] c_ARM    = 2'd0;
    localparam logic [1:0] c_IDLE   = 2'd1;
    localparam logic [1:0] c_ACTIVE = 2'd2;

    // Synchronized pins packed as {sclk, cs, mosi}
    logic [2:0] r_sync;

`ifdef SPI_DAISY_SYNC_EN
    logic [2:0] r_meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 3'b000;
            r_sync <= 3'b000;
        end else begin
            r_meta <= {bus.sclk, bus.cs, bus.mosi};
            r_sync <= r_meta;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {bus.sclk, bus.cs, bus.mosi};
        end
    end
`endif

    logic r_sclk_d;
    logic r_cs_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_d <= 1'b0;
            r_cs_d   <= 1'b0;
        end else begin
            r_sclk_d <= r_sync[2];
            r_cs_d   <= r_sync[1];
        end
    end

    logic w_sclk_s;
    logic w_cs_s;
    logic w_mosi_s;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_rise;
    logic w_cs_fall;

    assign w_sclk_s    = r_sync[2];
    assign w_cs_s      = r_sync[1];
    assign w_mosi_s    = r_sync[0];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;
    assign w_cs_fall   = ~w_cs_s & r_cs_d;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_miso;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_overrun;
    logic              r_frame_err;
    logic              r_busy;

    logic [DATA_W-1:0] w_shreg_nxt;

    assign w_shreg_nxt = {r_shreg[DATA_W-2:0], w_mosi_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ARM;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_miso      <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_rx_valid && bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            case (r_state)
                // Wait for cs high so a frame already in progress is never joined
                c_ARM: begin
                    if (w_cs_s) begin
                        r_state <= c_IDLE;
                    end
                end

                c_IDLE: begin
                    if (w_cs_fall) begin
                        r_shreg   <= bus.tx_data;
                        r_miso    <= bus.tx_data[DATA_W-1];
                        r_bit_cnt <= '0;
                        r_state   <= c_ACTIVE;
                        r_busy    <= 1'b1;
                    end
                end

                c_ACTIVE: begin
                    if (w_cs_rise) begin
                        r_state   <= c_IDLE;
                        r_busy    <= 1'b0;
                        r_miso    <= 1'b0;
                        r_bit_cnt <= '0;
                        if (r_bit_cnt != '0) begin
                            r_frame_err <= 1'b1;
                        end
                    end else if (w_sclk_rise) begin
                        // shreg keeps the received word so it shifts out next frame
                        r_shreg <= w_shreg_nxt;
                        if (r_bit_cnt == c_LAST) begin
                            r_bit_cnt <= '0;
                            if (!r_rx_valid || bus.rx_ready) begin
                                r_rx_data  <= w_shreg_nxt;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (w_sclk_fall) begin
                        r_miso <= r_shreg[DATA_W-1];
                    end
                end

                default: begin
                    r_state <= c_ARM;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.miso      = r_miso;
    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.overrun   = r_overrun;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/spi_daisy_slave.md
# spi_daisy_slave

SPI mode-0 slave node for the daisy-chain, sitting directly downstream of the SPI master's sclk/cs/mosi outputs and upstream of the next chained device. It oversamples the SPI pins in the system clock domain, shifts in mosi on sclk rising edges, and shifts out on miso on falling edges. It loads a local transmit byte at frame start and then forwards received bytes, giving classic daisy-chain pass-through. Each completed 8-bit frame is presented on a valid/ready interface.

## Interface
- DATA_W, 8: frame width in bits (≥2).
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock from the master, asynchronous to clk, CPOL=0.
- cs  in  1  active-low chip select.
- mosi  in  1  serial data in, from the master or the previous chained device.
- miso  out  1  serial data out, to the next chained device or back to the master.
- tx_data  in  DATA_W  byte to send first; sampled at the frame-start event.
- rx_data  out  DATA_W  last completed frame.
- rx_valid  out  1  rx_data holds unread data.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- overrun  out  1  one-cycle pulse: a frame completed while rx_valid was still high.
- frame_err  out  1  one-cycle pulse: cs deasserted with 1..DATA_W-1 bits received.
- busy  out  1  high in the ACTIVE state.

## Operation
- Input conditioning: sclk, cs, and mosi pass through identical synchronizer depth. One further "previous" flop on sclk and cs gives edge detection.
- Synchronizer reset values: sclk 0, cs 0, mosi 0.
- States:
  - ARM: reset state. Moves to IDLE when synced cs = 1. This prevents joining a frame mid-way.
  - IDLE: waits for a cs falling edge. On that edge: shreg ← tx_data, miso ← tx_data[DATA_W-1], bit_cnt ← 0, then go to ACTIVE.
  - ACTIVE:
    - sclk rising: shreg ← {shreg[DATA_W-2:0], mosi_s}; bit_cnt increments.
    - sclk falling: miso ← shreg[DATA_W-1].
    - On the rising edge that completes bit DATA_W: rx_data ← new shreg value, rx_valid ← 1, bit_cnt wraps to 0.
    - shreg is NOT reloaded at the frame boundary. The received byte shifts out in the next frame (pass-through).
    - cs rising: go to IDLE, miso ← 0. If bit_cnt ≠ 0, pulse frame_err and discard the partial frame.
- Handshake:
  - rx_valid clears on the cycle after rx_valid && rx_ready.
  - If a frame completes in the same cycle as an accept, rx_valid stays 1 with the new data and there is no overrun.
  - If a frame completes while rx_valid = 1 with no accept: pulse overrun, keep the old rx_data, drop the new frame.
- Event priority:
  - A cs rising edge wins over an sclk edge detected in the same cycle.
  - A sclk rising edge detected in IDLE or ARM is ignored.
- Reset values: miso 0, rx_data 0, rx_valid 0, overrun 0, frame_err 0, busy 0, state ARM.
- Reset mid-frame aborts silently, with no frame_err. The block needs cs to go high before the next frame.

## Timing
- A pin transition first sampled at clk edge t takes effect (shift, miso update, state change, rx_valid) at edge t+2 with SPI_DAISY_SYNC_EN, or t+1 without it.
- sclk high and low phases must each be ≥2 clk cycles. The master's 4-clk sclk period meets this.
- mosi must be stable from 1 clk before the sclk rising edge until 1 clk after it.
- Latency from the final sclk rising edge to rx_valid equals the synchronizer latency above.
- miso changes within synchronizer latency after each sclk falling edge, or after a cs edge.
- overrun and frame_err are single-cycle pulses.

## Configuration
- SPI_DAISY_SYNC_EN:
  - Defined: two synchronizer flops per input plus the edge flop. Use this for a truly asynchronous master.
  - Undefined: one register stage per input plus the edge flop. Use this when the master shares clk; it saves one cycle of latency.
- Functional behaviour is otherwise identical in both builds.

## Test plan
- Reset: assert rst for 3 cycles with cs = 1. Then cs ↓, tx_data = 8'hA5, master sends 8'h12 → miso bits 1,0,1,0,0,1,0,1; rx_data = 8'h12; rx_valid = 1; frame_err = 0.
- Daisy pass-through: tx_data = 8'h3C, master sends 16 bits 8'h12,8'h34 in one cs window → frame 1 miso = 8'h3C, frame 2 miso = 8'h12; rx_valid after each frame (rx_ready = 1); final rx_data = 8'h34.
- Overrun: hold rx_ready = 0 and send 8'h11 then 8'h22 → rx_data stays 8'h11, overrun pulses once at frame 2 completion. Then rx_ready = 1 for 1 cycle → rx_valid = 0.
- Abort: raise cs after 5 bits → frame_err pulses once, rx_valid = 0, miso = 0, state IDLE. The next full frame 8'hF0 is received correctly.
- Reset mid-frame: rst during bit 3 while cs stays low → no rx_valid; bits received before cs rises are ignored. A following cs-high/low frame of 8'h5A is received correctly.
- Simultaneous: a frame completes in the same cycle rx_ready accepts the prior frame → rx_valid stays 1 with the new data, no overrun.
